unrot_seq: RTL and testbench
============================

Name: unrot_seq

Overview:
- Sequential inverse of the combinational barrel rotator. Takes a word that was rotated right by k and rotates it left by k, restoring the original word.
- Processes one log2 stage per clock. Stages run in the same order as the forward rotator: largest shift first.
- Uses valid/ready handshakes on input and output. Intended for the decode/receive side of datapaths that use the forward rotator, where area matters more than throughput.

Parameters:
- N, 32, word width in bits; must equal 2^log2_N.
- log2_N, 5, rotation-amount width and number of stages.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_bits/in_k.
- in_ready  output  1  block can accept a word.
- in_bits  input  [0:N-1]  rotated word; index 0 is leftmost/MSB.
- in_k  input  [0:log2_N-1]  rotation amount; index 0 is MSB (weight N/2).
- out_valid  output  1  out_bits holds a result.
- out_ready  input  1  consumer accepts the result.
- out_bits  output  [0:N-1]  restored word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Function: out_bits[j] = in_bits[(j + k) mod N] for all j (left rotate by k). For any x and k, this block applied to the forward rotator's output for (x, k) yields x.
- Registers:
  - data_r, N bits.
  - k_r, log2_N bits.
  - stage_cnt, log2_N bits, counts 0..log2_N-1.
  - state, one of IDLE, RUN, DONE.
- Reset: if rst is high at an edge, state <= IDLE, stage_cnt <= 0, data_r <= 0, k_r <= 0. Reset overrides every other event, including mid-RUN and mid-DONE. Any in-flight word is dropped with no output.
- Output reset values: out_valid = 0, out_bits = 0, busy = 0. in_ready = 0 while rst is high.
- in_ready = (state == IDLE) && !rst. This is combinational from state only; it does not depend on in_valid or out_ready.
- out_valid = (state == DONE). out_bits = data_r in all states; it is only meaningful while out_valid is high.
- IDLE:
  - On in_valid && in_ready: data_r <= in_bits, k_r <= in_k, stage_cnt <= 0, go to RUN.
  - Otherwise hold.
- RUN, stage s = stage_cnt:
  - If k_r[s] = 1: data_r <= data_r rotated left by N >> (s+1), i.e. data_r[j] <= data_r[(j + (N >> (s+1))) mod N].
  - If k_r[s] = 0: data_r holds.
  - If s == log2_N-1, go to DONE. Otherwise stage_cnt <= s+1.
  - Index arithmetic is modulo N, done with log2_N-bit wrap. No out-of-range indices.
- DONE:
  - Hold data_r while out_ready = 0; out_bits must stay stable under backpressure.
  - On out_ready = 1: go to IDLE, stage_cnt <= 0.
- Latency: handshake at edge T → out_valid high after edge T+log2_N. This holds for every k, including k = 0; stage skipping is not allowed.
- Throughput: at most one word per log2_N+2 cycles. No overlap: in_ready stays low in DONE even when out_ready is high.
- Input ignored while busy: in_valid in RUN or DONE has no effect, and no internal state changes. The producer must hold its word until in_ready.
- out_ready in IDLE or RUN is ignored.
- No X propagation: data_r must never be loaded from unknown state after reset.

Test Plan:
- N=8, log2_N=3: reset, then in_bits=8'b1000_0000 (index 0 = 1), in_k=3 → out_valid 3 cycles after accept; out_bits=8'b0000_0100 (bit 5 set).
- N=8, in_bits=8'b1011_0001, in_k=0 → out_bits=8'b1011_0001 after exactly 3 cycles; busy high for RUN plus DONE.
- N=32 round trip: drive the forward rotator with random x and every k in 0..31, feed its output and k into this block → out_bits == x for all 32 k. Also cover x = 32'h0000_0001 and 32'hFFFF_FFFE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_bits constant, in_ready 0. Then raise out_ready for 1 cycle → IDLE, in_ready=1 next cycle.
- Busy drop: pulse in_valid with a different word during RUN → ignored; the first result is unchanged and no second result appears.
- Reset mid-RUN (after stage 1): assert rst 1 cycle → out_valid=0, busy=0, out_bits=0, in_ready=1 after deassert. A new word then completes with correct output.

Source files
------------

// File: rtl/unrot_seq_if.sv
// Handshake bundle for the sequential un-rotator: an input word with its
// rotation amount, the restored result, and a busy indicator.
interface unrot_seq_if #(
  parameter int N      = 32,
  parameter int log2_N = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [0:N-1]      in_bits;
  logic [0:log2_N-1] in_k;
  logic              out_valid;
  logic              out_ready;
  logic [0:N-1]      out_bits;
  logic              busy;

  // Producer/consumer side (drives the word in, accepts the result).
  modport master (
    output in_valid, in_bits, in_k, out_ready,
    input  in_ready, out_valid, out_bits, busy
  );

  // Un-rotator side.
  modport slave (
    input  in_valid, in_bits, in_k, out_ready,
    output in_ready, out_valid, out_bits, busy
  );
endinterface

// File: rtl/unrot_seq.sv
// Sequential inverse of the barrel rotator: a word rotated right by k is
// rotated left by k, one log2 stage per clock, largest shift first.
// Every word takes exactly log2_N RUN cycles regardless of k.
module unrot_seq #(
  parameter int N      = 32,
  parameter int log2_N = 5
) (
  input logic       clk,
  input logic       rst,
  unrot_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [0:N-1]      data_q;
  logic [0:log2_N-1] k_q;
  logic [log2_N-1:0] stage_q;

  logic [0:N-1]      rot_d;
  logic [log2_N-1:0] shift_amt;
  logic [log2_N-1:0] src_idx;
  logic              last_stage;

  // Candidate data for the current stage: data_q rotated left by N >> (s+1).
  always_comb begin
    rot_d     = '0;
    src_idx   = '0;
    shift_amt = log2_N'(N >> (32'(stage_q) + 1));
    for (int j = 0; j < N; j++) begin
      // Index addition wraps in log2_N bits, which is exactly mod N.
      src_idx  = log2_N'(j) + shift_amt;
      rot_d[j] = data_q[src_idx];
    end
  end

  assign last_stage = (stage_q == log2_N'(log2_N - 1));

  // Control FSM and datapath registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    // NOTE: the data and amount registers are cleared too, so out_bits reads
    // 0 after reset and no unknown value can ever reach a later stage.
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      data_q  <= '0;
      k_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update
      // simultaneous, so the order of statements below does not matter.
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_bits;
            k_q     <= bus.in_k;
            stage_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (k_q[stage_q]) begin
            data_q <= rot_d;
          end
          if (last_stage) begin
            state_q <= DONE;
          end else begin
            stage_q <= stage_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            stage_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.out_bits  = data_q;

endmodule

// File: tb/tb_unrot_seq.sv
// Directed bench for unrot_seq: an 8-bit instance for hand-computed vectors,
// handshake and reset cases, and a 32-bit instance for forward/inverse
// round trips over every rotation amount.
module tb_unrot_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  unrot_seq_if #(.N(8),  .log2_N(3)) if8 ();
  unrot_seq_if #(.N(32), .log2_N(5)) if32 ();

  unrot_seq #(.N(8),  .log2_N(3)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  unrot_seq #(.N(32), .log2_N(5)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one word for one cycle.
  task automatic send8(input logic [7:0] bits, input logic [2:0] k);
    int c = 0;
    while (!if8.in_ready && c < 20) begin
      tick();
      c++;
    end
    check1("in8_ready_wait", c < 20, 1'b1);
    if8.in_bits  = bits;
    if8.in_k     = k;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
  endtask

  // After an accept: out_valid low for two edges, high on the third.
  task automatic lat8(input string tag);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check1(tag, if8.out_valid, i == 3);
      check1("busy8_active", if8.busy, 1'b1);
    end
  endtask

  task automatic consume8();
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
  endtask

  // Forward rotator model: rotate right by k, index 0 is the MSB.
  function automatic logic [0:31] fwd32(input logic [0:31] x, input int k);
    logic [0:31] y;
    for (int j = 0; j < 32; j++) y[(j + k) % 32] = x[j];
    return y;
  endfunction

  // One 32-bit round trip with out_ready held high; latency must be 5.
  task automatic rt32(input logic [31:0] x, input int k);
    int c = 0;
    while (!if32.in_ready && c < 20) begin
      tick();
      c++;
    end
    check1("in32_ready_wait", c < 20, 1'b1);
    if32.in_bits  = fwd32(x, k);
    if32.in_k     = 5'(k);
    if32.in_valid = 1'b1;
    tick();
    if32.in_valid = 1'b0;
    c = 0;
    while (!if32.out_valid && c < 40) begin
      tick();
      c++;
    end
    check("rt32_latency", 32'(c), 32'd5);
    check("rt32_bits", if32.out_bits, x);
    tick();
  endtask

  initial begin
    if8.in_valid   = 1'b0;
    if8.in_bits    = '0;
    if8.in_k       = '0;
    if8.out_ready  = 1'b0;
    if32.in_valid  = 1'b0;
    if32.in_bits   = '0;
    if32.in_k      = '0;
    if32.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check1("rst_in_ready_low", if8.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check1("rst_out_valid", if8.out_valid, 1'b0);
    check1("rst_busy", if8.busy, 1'b0);
    check("rst_out_bits", 32'(if8.out_bits), 32'h0);
    check1("rst_in_ready", if8.in_ready, 1'b1);
    check1("rst32_in_ready", if32.in_ready, 1'b1);
    check("rst32_out_bits", if32.out_bits, 32'h0);

    // Single leftmost bit, k=3 -> bit index 5
    send8(8'h80, 3'd3);
    lat8("t1_latency");
    check("t1_bits", 32'(if8.out_bits), 32'h04);
    consume8();

    // k=0 still takes three stages
    send8(8'hB1, 3'd0);
    lat8("t2_latency");
    check("t2_bits", 32'(if8.out_bits), 32'hB1);
    consume8();
    check1("t2_busy_clear", if8.busy, 1'b0);

    // Backpressure in DONE
    send8(8'hA5, 3'd4);
    lat8("bp_latency");
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("bp_out_valid", if8.out_valid, 1'b1);
      check("bp_bits", 32'(if8.out_bits), 32'h5A);
      check1("bp_in_ready", if8.in_ready, 1'b0);
    end
    if8.out_ready = 1'b1;
    #1;
    check1("bp_no_overlap", if8.in_ready, 1'b0);
    tick();
    if8.out_ready = 1'b0;
    check1("bp_idle_ready", if8.in_ready, 1'b1);
    check1("bp_idle_valid", if8.out_valid, 1'b0);

    // Input pulsed during RUN is ignored
    send8(8'hC0, 3'd1);
    tick();
    if8.in_bits  = 8'hFF;
    if8.in_k     = 3'd0;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick();
    check1("drop_out_valid", if8.out_valid, 1'b1);
    check("drop_bits", 32'(if8.out_bits), 32'h81);
    consume8();
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("drop_no_second", if8.out_valid, 1'b0);
      check1("drop_idle", if8.busy, 1'b0);
    end

    // Reset after stage 1 drops the in-flight word
    send8(8'h01, 3'd2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check1("mrst_out_valid", if8.out_valid, 1'b0);
    check1("mrst_busy", if8.busy, 1'b0);
    check("mrst_out_bits", 32'(if8.out_bits), 32'h0);
    check1("mrst_in_ready", if8.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("mrst_dropped", if8.out_valid, 1'b0);
    end
    send8(8'h01, 3'd6);
    lat8("mrst_latency");
    check("mrst_new_bits", 32'(if8.out_bits), 32'h40);
    consume8();

    // 32-bit round trips over every k
    for (int k = 0; k < 32; k++) rt32($urandom, k);
    rt32(32'h0000_0001, 1);
    rt32(32'h0000_0001, 31);
    rt32(32'hFFFF_FFFE, 7);
    rt32(32'hFFFF_FFFE, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
